// File: rtl/bus_access_sequencer_pkg.sv
// Shared constants for the bus access sequencer: address-mux select codes,
// state encodings and the counter width helper.
package bus_access_sequencer_pkg;

    localparam logic [1:0] ADDR_BUSX_PC_A      = 2'd0;
    localparam logic [1:0] ADDR_BUSX_ALU_R     = 2'd1;
    localparam logic [1:0] ADDR_BUSX_ALUB_DATA = 2'd2;

    typedef enum logic [1:0] {
        BUS_SEQ_IDLE   = 2'd0,
        BUS_SEQ_SETUP  = 2'd1,
        BUS_SEQ_ACCESS = 2'd2,
        BUS_SEQ_DONE   = 2'd3
    } bus_seq_state_e;

    // Bits needed to hold max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module bus_wait_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/bus_access_sequencer.sv
// Arbitrates fetch vs data requests and sequences each memory cycle (SETUP/ACCESS/DONE).
// Define BUS_SEQ_TIMEOUT_EN to add the ACCESS timeout counter and the BUS_ERR pulse.
module bus_access_sequencer
    import bus_access_sequencer_pkg::*;
#(
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FETCH_REQ,
    input  logic       DATA_REQ,
    input  logic       DATA_WR,
    input  logic       DATA_ADDR_SEL,
    input  logic       MEM_READY,
    output logic [1:0] ADDR_BUSX,
    output logic       RD,
    output logic       WR,
    output logic       FETCH_ACK,
    output logic       DATA_ACK,
    output logic       BUSY,
    output logic       BUS_ERR
);

    localparam int            WW        = cnt_width(WAIT_STATES);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("WAIT_STATES must be in 0..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bus_seq_state_e state_q, state_d;
    logic [1:0]     addr_busx_q, addr_busx_d;
    logic           rd_q, rd_d, wr_q, wr_d;
    logic           fetch_ack_q, fetch_ack_d, data_ack_q, data_ack_d;
    logic           busy_q, busy_d;
    logic           is_data_q, is_data_d, is_wr_q, is_wr_d;
    logic           wait_load, wait_dec, wait_expired;
    logic           finish;

    bus_wait_counter #(.W(WW)) u_wait_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .expired  (wait_expired)
    );

`ifdef BUS_SEQ_TIMEOUT_EN
    // Loaded with TIMEOUT_CYCLES-1 so expiry lands on the last allowed post-wait cycle.
    localparam int            TW      = cnt_width(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic to_load, to_dec, to_expired;
    logic bus_err_q, bus_err_d;

    bus_wait_counter #(.W(TW)) u_timeout_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (to_load),
        .load_val (TO_LOAD),
        .dec      (to_dec),
        .expired  (to_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        addr_busx_d = addr_busx_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        fetch_ack_d = 1'b0;
        data_ack_d  = 1'b0;
        is_data_d   = is_data_q;
        is_wr_d     = is_wr_q;
        wait_load   = 1'b0;
        wait_dec    = 1'b0;
        finish      = 1'b0;
`ifdef BUS_SEQ_TIMEOUT_EN
        to_load     = 1'b0;
        to_dec      = 1'b0;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            BUS_SEQ_IDLE: begin
`ifdef BUS_SEQ_TIMEOUT_EN
                to_load = 1'b1;
`endif
                if (DATA_REQ) begin
                    state_d     = BUS_SEQ_SETUP;
                    is_data_d   = 1'b1;
                    is_wr_d     = DATA_WR;
                    addr_busx_d = DATA_ADDR_SEL ? ADDR_BUSX_ALU_R : ADDR_BUSX_ALUB_DATA;
                end else if (FETCH_REQ) begin
                    state_d     = BUS_SEQ_SETUP;
                    is_data_d   = 1'b0;
                    is_wr_d     = 1'b0;
                    addr_busx_d = ADDR_BUSX_PC_A;
                end
            end
            BUS_SEQ_SETUP: begin
                state_d   = BUS_SEQ_ACCESS;
                rd_d      = ~is_wr_q;
                wr_d      = is_wr_q;
                wait_load = 1'b1;
            end
            BUS_SEQ_ACCESS: begin
                rd_d = ~is_wr_q;
                wr_d = is_wr_q;
                if (!wait_expired) begin
                    wait_dec = 1'b1;
                end else if (MEM_READY) begin
                    finish = 1'b1;
`ifdef BUS_SEQ_TIMEOUT_EN
                end else if (to_expired) begin
                    finish    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    to_dec = 1'b1;
`endif
                end
            end
            BUS_SEQ_DONE: state_d = BUS_SEQ_IDLE;
            default:      state_d = BUS_SEQ_IDLE;
        endcase

        if (finish) begin
            state_d     = BUS_SEQ_DONE;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            fetch_ack_d = ~is_data_q;
            data_ack_d  = is_data_q;
        end
        busy_d = (state_d != BUS_SEQ_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= BUS_SEQ_IDLE;
            addr_busx_q <= ADDR_BUSX_PC_A;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            is_data_q   <= 1'b0;
            is_wr_q     <= 1'b0;
`ifdef BUS_SEQ_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_busx_q <= addr_busx_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            fetch_ack_q <= fetch_ack_d;
            data_ack_q  <= data_ack_d;
            busy_q      <= busy_d;
            is_data_q   <= is_data_d;
            is_wr_q     <= is_wr_d;
`ifdef BUS_SEQ_TIMEOUT_EN
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign ADDR_BUSX = addr_busx_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign FETCH_ACK = fetch_ack_q;
    assign DATA_ACK  = data_ack_q;
    assign BUSY      = busy_q;
`ifdef BUS_SEQ_TIMEOUT_EN
    assign BUS_ERR   = bus_err_q;
`else
    assign BUS_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_access_sequencer.sv
// Scoreboard bench for bus_access_sequencer: expected accesses are queued when a request
// is driven and checked by a monitor when the DUT acknowledges.
module tb_bus_access_sequencer;

    localparam int WS = 1;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst, fetch_req, data_req, data_wr, data_addr_sel, mem_ready;
    logic [1:0] addr_busx;
    logic       rd, wr, fetch_ack, data_ack, busy, bus_err;

    always #5 clk = ~clk;

    bus_access_sequencer #(.WAIT_STATES(WS), .TIMEOUT_CYCLES(TO)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .FETCH_REQ     (fetch_req),
        .DATA_REQ      (data_req),
        .DATA_WR       (data_wr),
        .DATA_ADDR_SEL (data_addr_sel),
        .MEM_READY     (mem_ready),
        .ADDR_BUSX     (addr_busx),
        .RD            (rd),
        .WR            (wr),
        .FETCH_ACK     (fetch_ack),
        .DATA_ACK      (data_ack),
        .BUSY          (busy),
        .BUS_ERR       (bus_err)
    );

    typedef struct {
        bit         is_data;
        bit         wr;
        logic [1:0] addr;
        int         ack_cyc;
        bit         err;
        int         stb;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void expect_acc(input bit d, input bit w, input logic [1:0] a,
                                       input int ack, input bit err, input int stb);
        exp_t e;
        e.is_data = d; e.wr = w; e.addr = a; e.ack_cyc = ack; e.err = err; e.stb = stb;
        exp_q.push_back(e);
    endfunction

    // Requester side: wait for the ACK (bounded) and drop REQ in the cycle it is seen.
    task automatic wait_ack(input bit d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d ? data_ack : fetch_ack) && n < 200);
        if (!(d ? data_ack : fetch_ack)) chk("ack_wait_timeout", 0, 1);
        if (d) data_req = 1'b0;
        else   fetch_req = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(negedge clk);
    endtask

    initial begin : mon
        int   stb = 0;
        bit   stb_wr = 0;
        bit   prev_ack = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stb = 0; stb_wr = 0; prev_ack = 0;
            end else begin
                chk("rd_wr_excl", rd & wr, 0);
                chk("ack_excl", fetch_ack & data_ack, 0);
                if (prev_ack) begin
                    chk("busy_after_ack", busy, 0);
                    chk("ack_single_pulse", fetch_ack | data_ack, 0);
                end
                if (rd | wr) begin
                    stb++;
                    if (wr) stb_wr = 1;
                end
                prev_ack = fetch_ack | data_ack;
                if (fetch_ack | data_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_kind", data_ack, e.is_data);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("addr_busx", addr_busx, e.addr);
                        chk("strobe_cycles", stb, e.stb);
                        chk("strobe_is_wr", stb_wr, e.wr);
                        chk("bus_err", bus_err, e.err);
                    end
                    stb = 0; stb_wr = 0;
                end else begin
                    chk("bus_err_no_ack", bus_err, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0;
        data_wr = 1'b0; data_addr_sel = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr_busx", addr_busx, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wr", wr, 0);
        chk("rst_fetch_ack", fetch_ack, 0);
        chk("rst_data_ack", data_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_err", bus_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain fetch.
        fetch_req = 1'b1;
        expect_acc(0, 0, 2'd0, cyc + 3 + WS, 0, WS + 1);
        wait_ack(0);
        gap();

        // Store via ALU_R.
        data_req = 1'b1; data_wr = 1'b1; data_addr_sel = 1'b1;
        expect_acc(1, 1, 2'd1, cyc + 3 + WS, 0, WS + 1);
        wait_ack(1);
        gap();

        // Load via ALUB_DATA.
        data_req = 1'b1; data_wr = 1'b0; data_addr_sel = 1'b0;
        expect_acc(1, 0, 2'd2, cyc + 3 + WS, 0, WS + 1);
        wait_ack(1);
        gap();

        // Simultaneous requests: data first, fetch in the following IDLE.
        data_req = 1'b1; fetch_req = 1'b1; data_wr = 1'b0; data_addr_sel = 1'b0;
        expect_acc(1, 0, 2'd2, cyc + 3 + WS, 0, WS + 1);
        expect_acc(0, 0, 2'd0, cyc + 7 + 2 * WS, 0, WS + 1);
        wait_ack(1);
        wait_ack(0);
        gap();

        // Data request arriving while a fetch is in flight.
        c0 = cyc;
        fetch_req = 1'b1;
        expect_acc(0, 0, 2'd0, c0 + 3 + WS, 0, WS + 1);
        expect_acc(1, 1, 2'd1, c0 + 7 + 2 * WS, 0, WS + 1);
        repeat (2) @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_addr_sel = 1'b1;
        wait_ack(0);
        wait_ack(1);
        gap();

        // REQ dropped mid-access still completes.
        fetch_req = 1'b1;
        expect_acc(0, 0, 2'd0, cyc + 3 + WS, 0, WS + 1);
        repeat (2) @(negedge clk);
        fetch_req = 1'b0;
        wait_ack(0);
        gap();

`ifdef BUS_SEQ_TIMEOUT_EN
        // MEM_READY stuck low: timeout after TO post-wait cycles.
        mem_ready = 1'b0;
        fetch_req = 1'b1;
        expect_acc(0, 0, 2'd0, cyc + 2 + WS + TO, 1, WS + TO);
        wait_ack(0);
        mem_ready = 1'b1;
        gap();
`else
        // MEM_READY low for 10 ACCESS cycles: strobe held, ACK one cycle after it rises.
        c0 = cyc;
        mem_ready = 1'b0;
        fetch_req = 1'b1;
        expect_acc(0, 0, 2'd0, c0 + 12, 0, 10);
        repeat (11) @(negedge clk);
        chk("rd_held_waiting", rd, 1);
        chk("busy_held_waiting", busy, 1);
        mem_ready = 1'b1;
        wait_ack(0);
        gap();
`endif

        // Reset during ACCESS: strobes drop, no ACK.
        data_req = 1'b1; data_wr = 1'b1; data_addr_sel = 1'b1;
        repeat (2) @(negedge clk);
        chk("wr_in_access", wr, 1);
        rst = 1'b1; data_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_wr", wr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data_ack", data_ack, 0);
        chk("mid_rst_addr_busx", addr_busx, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_busy", busy, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_access_sequencer.md
Name: bus_access_sequencer

Overview:
- Sequences every memory cycle on the CPU address bus.
- Arbitrates between the instruction-fetch requester (PC_A) and the data load/store requester (ALU_R or ALUB_DATA).
- Drives the address-bus mux select ADDR_BUSX and the RD/WR strobes, inserts wait states, and handshakes with memory via MEM_READY.
- Sits between the instruction decoder/control unit and the address-bus mux plus the memory interface.

Parameters:
- WAIT_STATES, 1: minimum extra ACCESS cycles beyond the first, before MEM_READY is honoured (0..15).
- TIMEOUT_CYCLES, 64: ACCESS cycles after the minimum before a bus error. Used only with BUS_SEQ_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- FETCH_REQ  input  1  instruction fetch request; held high until FETCH_ACK.
- DATA_REQ  input  1  data access request; held high until DATA_ACK.
- DATA_WR  input  1  1 = store, 0 = load; sampled at grant.
- DATA_ADDR_SEL  input  1  0 = address from ALUB_DATA, 1 = from ALU_R; sampled at grant.
- MEM_READY  input  1  memory completes the current access.
- ADDR_BUSX  output  2  address mux select.
- RD  output  1  memory read strobe.
- WR  output  1  memory write strobe.
- FETCH_ACK  output  1  one-cycle pulse: fetch done; instruction latch enable.
- DATA_ACK  output  1  one-cycle pulse: data access done; load data latch enable.
- BUSY  output  1  high in any state other than IDLE.
- BUS_ERR  output  1  one-cycle pulse coincident with ACK on timeout.

Behaviour:
- All outputs are registered.
- Reset values: ADDR_BUSX = ADDR_BUSX_PC_A; RD, WR, FETCH_ACK, DATA_ACK, BUSY, BUS_ERR = 0; state = IDLE; counters = 0.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - DATA_REQ has priority: grant data, latch DATA_WR and DATA_ADDR_SEL.
  - Otherwise, if FETCH_REQ is high, grant fetch.
  - Otherwise stay in IDLE; ADDR_BUSX holds its last value.
- SETUP (1 cycle):
  - ADDR_BUSX = PC_A (fetch), ALU_R or ALUB_DATA (data, per latched DATA_ADDR_SEL).
  - RD = WR = 0 (address setup).
- ACCESS:
  - ADDR_BUSX held. RD = 1 for fetch or load; WR = 1 for store.
  - Wait counter counts WAIT_STATES cycles; MEM_READY is ignored until the counter expires.
  - After expiry, the first cycle with MEM_READY = 1 moves to DONE.
- DONE (1 cycle):
  - RD = WR = 0; ADDR_BUSX held.
  - The granted requester's ACK = 1.
  - Next state is always IDLE. The requester drops REQ in the same cycle it sees ACK.
- Latency, request high at edge N, MEM_READY permanently high:
  - SETUP in cycle N+1.
  - ACCESS in N+2 .. N+2+WAIT_STATES.
  - ACK in N+3+WAIT_STATES.
  - IDLE again at N+4+WAIT_STATES.
- Simultaneous FETCH_REQ and DATA_REQ: data served first; fetch granted in the following IDLE.
- Requests arriving while BUSY are held off until IDLE.
- REQ deasserted mid-access: the access still completes and ACK still pulses.
- WAIT_STATES = 0: ACCESS may last a single cycle. Counter width is max(1, clog2(WAIT_STATES+1)).
- RESET mid-operation: next edge returns to IDLE with reset values. No ACK is issued and the strobes drop immediately.
- FETCH_ACK and DATA_ACK are never high together. RD and WR are never high together.

Optional Feature:
- BUS_SEQ_TIMEOUT_EN defined:
  - A timeout counter runs in ACCESS after the minimum wait.
  - After TIMEOUT_CYCLES cycles without MEM_READY, the block goes to DONE with the ACK pulse and BUS_ERR = 1.
  - The counter clears on entry to SETUP.
- Not defined:
  - ACCESS waits on MEM_READY indefinitely.
  - BUS_ERR is tied 0 and no timeout counter is synthesised.

Decomposition:
- The shared constants include file holds:
  - ADDR_BUSX_PC_A = 2'd0, ADDR_BUSX_ALU_R = 2'd1, ADDR_BUSX_ALUB_DATA = 2'd2.
  - State encodings BUS_SEQ_IDLE/SETUP/ACCESS/DONE = 2'd0..3.
- One sub-module: bus_wait_counter.
  - Loadable down-counter with an expired flag, parameterised width.
  - Instantiated for the wait-state counter, and for the timeout counter when enabled.

Test Plan:
- Reset then FETCH_REQ = 1, WAIT_STATES = 1, MEM_READY = 1 -> ADDR_BUSX = 0 in SETUP; RD high for 2 cycles; FETCH_ACK pulses at cycle 4; BUSY low at cycle 5.
- DATA_REQ = 1, DATA_WR = 1, DATA_ADDR_SEL = 1 -> ADDR_BUSX = 1, WR high, RD low, DATA_ACK single pulse.
- FETCH_REQ and DATA_REQ raised the same cycle, DATA_ADDR_SEL = 0 -> data access first with ADDR_BUSX = 2, then fetch; FETCH_ACK follows DATA_ACK by 5 cycles.
- MEM_READY held low 10 cycles into ACCESS -> RD stays high, no ACK; ACK one cycle after MEM_READY rises.
- RESET asserted during ACCESS -> next cycle RD = WR = 0, BUSY = 0, no ACK.
- With BUS_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 4, MEM_READY stuck low -> BUS_ERR and ACK pulse together after 4 post-wait cycles. Without the macro, BUS_ERR stays 0.
